frame_sequencer: RTL

- Parametrised top-level game/frame controller that generalises the fixed three-layer draw FSM.
- Sequences start handshake -> per-frame state update -> NUM_LAYERS draw phases -> frame-rate wait, repeating until game over; then an end-screen draw phase.
- Adds an internal frame timer, pause, per-layer draw watchdog, frame counter and overrun/timeout status.
- Sits between the keyboard/KEY inputs, the game-logic datapath and the VGA plot datapath.

---
 rtl/frame_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame controller: start handshake, per-frame update pulse, NUM_LAYERS draw
// phases under a per-layer watchdog, paced frame wait, and an end-screen draw.
module frame_sequencer #(
  parameter int NUM_LAYERS    = 3,
  parameter int FRAME_CYCLES  = 833333,
  parameter int LAYER_TIMEOUT = 65536,
  parameter int FC_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  end_done,
  output logic                  update,
  output logic                  plot,
  output logic [NUM_LAYERS-1:0] layer_sel,
  output logic                  draw_end,
  output logic [FC_W-1:0]       frame_count,
  output logic                  paused,
  output logic                  overrun,
  output logic [NUM_LAYERS-1:0] timeout_err,
  output logic                  busy
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TMR_W = $clog2(FRAME_CYCLES + 1);
  localparam int WD_W  = $clog2(LAYER_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYERS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LAYER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RELEASE,
    S_UPDATE,
    S_DRAW,
    S_WAIT_FRAME,
    S_DRAW_END,
    S_END
  } state_t;

  typedef struct packed {
    logic                  update;
    logic                  plot;
    logic                  draw_end;
    logic                  busy;
    logic [NUM_LAYERS-1:0] layer_sel;
  } outs_t;

  // Output bundle for a given destination state; loaded on every transition so
  // the strobes are registered yet always match the state being entered.
  function automatic outs_t decode(input state_t s, input logic [IDX_W-1:0] i);
    outs_t o;
    o      = '0;
    o.busy = (s != S_IDLE) && (s != S_END);
    case (s)
      S_UPDATE:   o.update = 1'b1;
      S_DRAW: begin
        o.plot      = 1'b1;
        o.layer_sel = NUM_LAYERS'(1) << i;
      end
      S_DRAW_END: begin
        o.plot     = 1'b1;
        o.draw_end = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [WD_W-1:0]  wd;
  outs_t            outs;

  logic frame_due;
  logic layer_end;
  logic last_layer;

  // timer holds cycles elapsed since the last update pulse, saturating at the
  // cycle in which the next update must be launched
  assign frame_due  = (timer == TMR_LAST);
  assign layer_end  = layer_done[idx] || (wd == WD_LAST);
  assign last_layer = (idx == IDX_LAST);

  assign update    = outs.update;
  assign plot      = outs.plot;
  assign draw_end  = outs.draw_end;
  assign busy      = outs.busy;
  assign layer_sel = outs.layer_sel;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      wd          <= '0;
      outs        <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= '0;
      paused      <= 1'b0;
    end else begin
      if (!paused && !frame_due)
        timer <= timer + 1'b1;

      case (state)
        S_IDLE, S_END: begin
          if (start) begin
            state <= S_WAIT_RELEASE;
            outs  <= decode(S_WAIT_RELEASE, '0);
          end
        end

        S_WAIT_RELEASE: begin
          if (!start) begin
            state       <= S_UPDATE;
            outs        <= decode(S_UPDATE, '0);
            frame_count <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
          end
        end

        S_UPDATE: begin
          timer <= TMR_W'(1);
          if (game_over) begin
            state <= S_DRAW_END;
            outs  <= decode(S_DRAW_END, '0);
          end else begin
            state       <= S_DRAW;
            idx         <= '0;
            wd          <= '0;
            frame_count <= frame_count + 1'b1;
            outs        <= decode(S_DRAW, '0);
          end
        end

        S_DRAW: begin
          if (layer_end) begin
            // a done arriving on the watchdog's last cycle counts as done
            if (!layer_done[idx])
              timeout_err[idx] <= 1'b1;
            wd <= '0;
            if (!last_layer) begin
              idx  <= idx + 1'b1;
              outs <= decode(S_DRAW, idx + 1'b1);
            end else if (frame_due) begin
              overrun <= 1'b1;
              state   <= S_UPDATE;
              outs    <= decode(S_UPDATE, '0);
            end else begin
              state <= S_WAIT_FRAME;
              outs  <= decode(S_WAIT_FRAME, '0);
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end

        S_WAIT_FRAME: begin
          // a paused cycle neither advances the timer nor launches the update
          if (!paused && frame_due) begin
            state <= S_UPDATE;
            outs  <= decode(S_UPDATE, '0);
          end else begin
            paused <= pause;
          end
        end

        S_DRAW_END: begin
          if (end_done) begin
            state <= S_END;
            outs  <= decode(S_END, '0);
          end
        end

        default: begin
          state <= S_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

endmodule
